dldo_mode_ctrl: RTL and testbench

Mode controller for the digital LDO's coarse/fine thermometer shift-register array. It watches the clocked comparator and the thermometer codes, and drives the coarse_en/fine_en enables. It sequences power-up coarse acquisition, fine tracking, coarse hand-off on fine saturation, and freezing on limit-cycle lock. It sits between the comparator and the shift-register top level and is the only source of its enables.

---
 rtl/dldo_ctrl_pkg.sv | 19 +
 rtl/dldo_act_cnt.sv | 32 +++
 rtl/dldo_mode_ctrl.sv | 103 ++++++++++
 tb/tb_dldo_mode_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dldo_ctrl_pkg.sv
// Shared definitions for the digital LDO mode controller and its neighbours:
// state encoding and default parameter values.
package dldo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COARSE = 2'd1,
    FINE   = 2'd2,
    LOCK   = 2'd3
  } dldo_state_e;

  localparam int DEF_L          = 16;
  localparam int DEF_M          = 16;
  localparam int DEF_LOCK_CNT   = 8;
  localparam int DEF_SAT_CYC    = 4;
  localparam int DEF_UNLOCK_CNT = 4;
  localparam int DEF_CNT_W      = 4;

endpackage

// File: rtl/dldo_act_cnt.sv
// Saturating activity counter: counts consecutive cycles with inc high,
// returns to zero whenever inc drops or clr is asserted.
module dldo_act_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (!clr_i && inc_i) begin
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dldo_mode_ctrl.sv
// Mode controller for the DLDO coarse/fine thermometer arrays: sequences
// coarse acquisition, fine tracking, coarse hand-off and limit-cycle lock.
module dldo_mode_ctrl
  import dldo_ctrl_pkg::*;
#(
  parameter int L          = DEF_L,
  parameter int M          = DEF_M,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int SAT_CYC    = DEF_SAT_CYC,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         comp_in,
  input  logic [L-1:0] fine_out,
  input  logic [M-1:0] coarse_out,
  output logic         fine_en,
  output logic         coarse_en,
  output logic         locked,
  output logic         coarse_sat,
  output logic [1:0]   state
);

  localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] SatLast    = CNT_W'(SAT_CYC - 1);
  localparam logic [CNT_W-1:0] UnlockLast = CNT_W'(UNLOCK_CNT - 1);

  dldo_state_e      state_q, state_d;
  logic             comp_q, comp_v_q, coarse_sat_q, coarse_sat_d;
  logic             toggle, fineSat, coarseSat, stateChange;
  logic [CNT_W-1:0] togCnt, holdCnt, satCnt;

  // comp_v masks the first compare after leaving IDLE so the reset value of
  // comp_q can never masquerade as a crossing.
  assign toggle    = comp_v_q & (comp_in != comp_q);
  assign fineSat   = (&fine_out & comp_in) | (~|fine_out & ~comp_in);
  assign coarseSat = (&coarse_out & comp_in) | (~|coarse_out & ~comp_in);

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   state_d = COARSE;
        COARSE: if (toggle && !coarseSat) state_d = FINE;
        FINE: begin
          if (fineSat && satCnt == SatLast) state_d = COARSE;
          else if (toggle && togCnt == LockLast) state_d = LOCK;
        end
        LOCK:   if (!toggle && holdCnt == UnlockLast) state_d = FINE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign stateChange = (state_d != state_q);

  always_comb begin
    coarse_sat_d = coarse_sat_q;
    if (state_d != COARSE) begin
      coarse_sat_d = 1'b0;
    end else if (state_q == COARSE && coarseSat) begin
      coarse_sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      comp_q       <= 1'b0;
      comp_v_q     <= 1'b0;
      coarse_sat_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      comp_q       <= comp_in;
      comp_v_q     <= (state_q != IDLE);
      coarse_sat_q <= coarse_sat_d;
    end
  end

  dldo_act_cnt #(.CNT_W(CNT_W)) u_tog_cnt (
    .clk(clk), .rst(rst), .inc_i(toggle), .clr_i(stateChange), .cnt_o(togCnt)
  );

  dldo_act_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk(clk), .rst(rst), .inc_i(~toggle), .clr_i(stateChange), .cnt_o(holdCnt)
  );

  dldo_act_cnt #(.CNT_W(CNT_W)) u_sat_cnt (
    .clk(clk), .rst(rst), .inc_i(fineSat), .clr_i(stateChange), .cnt_o(satCnt)
  );

  // Enables decode purely from the state register, so they can never overlap.
  assign coarse_en  = (state_q == COARSE);
  assign fine_en    = (state_q == FINE);
  assign locked     = (state_q == LOCK);
  assign coarse_sat = coarse_sat_q;
  assign state      = state_q;

endmodule

// File: tb/tb_dldo_mode_ctrl.sv
// Self-checking bench for dldo_mode_ctrl: a run-length model of the mode
// rules checked every cycle, plus literal expectations at key points.
module tb_dldo_mode_ctrl;

  localparam int L = 16;
  localparam int M = 16;
  localparam int LOCK_CNT = 8;
  localparam int SAT_CYC = 4;
  localparam int UNLOCK_CNT = 4;
  localparam logic [15:0] MID = 16'h00FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic comp_in = 1'b1;
  logic [L-1:0] fine_out = MID;
  logic [M-1:0] coarse_out = MID;
  logic fine_en, coarse_en, locked, coarse_sat;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  dldo_mode_ctrl #(
    .L(L), .M(M), .LOCK_CNT(LOCK_CNT), .SAT_CYC(SAT_CYC),
    .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .comp_in(comp_in),
    .fine_out(fine_out), .coarse_out(coarse_out),
    .fine_en(fine_en), .coarse_en(coarse_en), .locked(locked),
    .coarse_sat(coarse_sat), .state(state)
  );

  always #5 clk = ~clk;

  // Model: mode as an integer and run lengths of consecutive events in it.
  int  mMode = 0;
  int  togRun = 0, holdRun = 0, satRun = 0;
  bit  prevComp = 0, prevValid = 0, mCsat = 0;

  always @(posedge clk or posedge rst) begin
    bit tg, fs, cs;
    int nm;
    if (rst) begin
      mMode = 0; togRun = 0; holdRun = 0; satRun = 0;
      prevComp = 0; prevValid = 0; mCsat = 0;
    end else begin
      tg = prevValid && (comp_in != prevComp);
      fs = (fine_out == 16'hFFFF && comp_in) || (fine_out == 16'h0000 && !comp_in);
      cs = (coarse_out == 16'hFFFF && comp_in) || (coarse_out == 16'h0000 && !comp_in);
      nm = mMode;
      if (!en) nm = 0;
      else if (mMode == 0) nm = 1;
      else if (mMode == 1) begin
        if (tg && !cs) nm = 2;
      end else if (mMode == 2) begin
        if (fs && satRun + 1 == SAT_CYC) nm = 1;
        else if (tg && togRun + 1 == LOCK_CNT) nm = 3;
      end else begin
        if (!tg && holdRun + 1 == UNLOCK_CNT) nm = 2;
      end
      if (nm != 1) mCsat = 0;
      else if (mMode == 1 && cs) mCsat = 1;
      if (nm != mMode) begin
        togRun = 0; holdRun = 0; satRun = 0;
      end else begin
        togRun  = tg  ? ((togRun  < 15) ? togRun + 1  : 15) : 0;
        holdRun = !tg ? ((holdRun < 15) ? holdRun + 1 : 15) : 0;
        satRun  = fs  ? ((satRun  < 15) ? satRun + 1  : 15) : 0;
      end
      prevValid = (mMode != 0);
      prevComp = comp_in;
      mMode = nm;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    checkOutput("model.state", int'(state), mMode);
    checkOutput("model.coarse_en", int'(coarse_en), int'(mMode == 1));
    checkOutput("model.fine_en", int'(fine_en), int'(mMode == 2));
    checkOutput("model.locked", int'(locked), int'(mMode == 3));
    checkOutput("model.coarse_sat", int'(coarse_sat), int'(mCsat));
    checkOutput("enables_exclusive", int'(fine_en & coarse_en), 0);
  end

  // Apply inputs, take one clock edge, return shortly after that edge.
  task automatic applyStimulus(input logic e, input logic c,
                               input logic [15:0] f, input logic [15:0] co);
    en = e; comp_in = c; fine_out = f; coarse_out = co;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset.state", int'(state), 0);
    checkOutput("reset.coarse_sat", int'(coarse_sat), 0);
    rst = 1'b0;

    applyStimulus(1, 1, MID, MID);
    checkOutput("idle_to_coarse.state", int'(state), 1);
    checkOutput("idle_to_coarse.coarse_en", int'(coarse_en), 1);
    applyStimulus(1, 1, MID, MID);
    checkOutput("coarse_first_cycle_hold", int'(state), 1);
    applyStimulus(1, 0, MID, MID);
    checkOutput("coarse_to_fine.state", int'(state), 2);
    checkOutput("coarse_to_fine.coarse_en", int'(coarse_en), 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, (i % 2 == 0) ? 1'b1 : 1'b0, MID, MID);
      if (i == 6) checkOutput("seven_toggles_still_fine", int'(state), 2);
    end
    checkOutput("lock.state", int'(state), 3);
    checkOutput("lock.locked", int'(locked), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, MID, MID);
      if (i == 2) checkOutput("unlock_three_holds", int'(state), 3);
    end
    checkOutput("unlock.state", int'(state), 2);

    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 16'hFFFF, MID);
    applyStimulus(1, 0, 16'hFFFF, MID);
    checkOutput("three_sat_stays_fine", int'(state), 2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 16'hFFFF, MID);
      if (i == 2) checkOutput("sat_third_cycle_fine", int'(state), 2);
    end
    checkOutput("fine_sat_handoff", int'(state), 1);

    applyStimulus(1, 0, MID, 16'h0000);
    checkOutput("coarse_sat_set", int'(coarse_sat), 1);
    checkOutput("coarse_sat_stay", int'(state), 1);
    applyStimulus(1, 0, MID, 16'h0000);
    checkOutput("coarse_sat_sticky", int'(coarse_sat), 1);
    applyStimulus(1, 1, MID, 16'h0000);
    checkOutput("coarse_sat_exit.state", int'(state), 2);
    checkOutput("coarse_sat_exit.flag", int'(coarse_sat), 0);

    applyStimulus(1, 0, MID, MID);
    applyStimulus(1, 1, MID, MID);
    applyStimulus(1, 0, MID, MID);
    applyStimulus(1, 1, MID, MID);
    applyStimulus(1, 0, 16'h0000, MID);
    applyStimulus(1, 1, 16'hFFFF, MID);
    applyStimulus(1, 0, 16'h0000, MID);
    checkOutput("priority_pre.state", int'(state), 2);
    applyStimulus(1, 1, 16'hFFFF, MID);
    checkOutput("sat_beats_lock.state", int'(state), 1);
    checkOutput("sat_beats_lock.locked", int'(locked), 0);

    applyStimulus(1, 0, MID, MID);
    checkOutput("back_to_fine", int'(state), 2);
    for (int i = 0; i < 8; i++) applyStimulus(1, (i % 2 == 0) ? 1'b1 : 1'b0, MID, MID);
    checkOutput("relock", int'(state), 3);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst.state", int'(state), 0);
    checkOutput("async_rst.locked", int'(locked), 0);
    checkOutput("async_rst.enables", int'(fine_en | coarse_en), 0);
    @(posedge clk);
    #2 rst = 1'b0;

    applyStimulus(1, 1, MID, MID);
    applyStimulus(1, 1, MID, MID);
    applyStimulus(1, 0, MID, MID);
    checkOutput("fine_before_disable", int'(state), 2);
    applyStimulus(0, 1, MID, MID);
    checkOutput("disable_to_idle.state", int'(state), 0);
    checkOutput("disable_to_idle.fine_en", int'(fine_en), 0);
    applyStimulus(0, 0, MID, MID);
    applyStimulus(0, 1, MID, MID);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
